// File: rtl/bayer_pkg.sv
// Shared constants and types for the Bayer-quad to grayscale downscaler.
// Widths are sized so the 2x2 sum of full-scale samples never overflows.
package bayer_pkg;

  localparam int DATA_W    = 12;
  localparam int IN_WIDTH  = 1280;
  localparam int CNT_W     = 16;
  localparam int OUT_WIDTH = IN_WIDTH / 2;
  localparam int PAIR_W    = DATA_W + 1;
  localparam int QUAD_W    = DATA_W + 2;
  localparam int ADDR_W    = $clog2(OUT_WIDTH);
  localparam int POS_W     = 10;

  typedef enum logic {
    ROW_FOLD = 1'b0,
    ROW_COMB = 1'b1
  } row_state_t;

  // Line-buffer slot that holds the column pair containing column x.
  function automatic logic [ADDR_W-1:0] pair_addr(input logic [CNT_W-1:0] x);
    return ADDR_W'(x >> 1);
  endfunction

endpackage

// File: rtl/line_buf_sdp.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Contents are never reset; readers must only fetch slots written earlier.
module line_buf_sdp
  import bayer_pkg::*;
#(
  parameter int DEPTH = OUT_WIDTH,
  parameter int WIDTH = PAIR_W,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bayer_quad_gray.sv
// Folds even Bayer rows into column-pair sums, then combines each odd row
// with those sums to emit one 12-bit gray pixel (quad mean) per 2x2 quad.
module bayer_quad_gray
  import bayer_pkg::*;
(
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [CNT_W-1:0]  iX_Cont,
  input  logic [CNT_W-1:0]  iY_Cont,
  output logic [DATA_W-1:0] oGRAY,
  output logic              oDVAL,
  output logic [POS_W-1:0]  oX,
  output logic [POS_W-1:0]  oY
);

  row_state_t        state;
  row_state_t        next_state;

  logic [PAIR_W-1:0] half_sum;
  logic              armed;
  logic [CNT_W-1:0]  armed_x;
  logic [CNT_W-1:0]  armed_y;

  logic              buf_valid;
  logic [CNT_W-2:0]  buf_row;

  logic              rd_pending;
  logic [PAIR_W-1:0] rd_hold;
  logic [PAIR_W-1:0] rd_data;
  logic [PAIR_W-1:0] rd_value;

  logic              beat;
  logic              paired;
  logic              buf_match;
  logic [CNT_W-2:0]  row_tag;
  logic [ADDR_W-1:0] col_addr;
  logic [PAIR_W-1:0] pair_sum;
  logic [QUAD_W-1:0] quad_sum;

  logic              latch_half;
  logic              arm;
  logic              disarm;
  logic              wr_en;
  logic              rd_en;
  logic              fire;

  // Columns beyond the active width are treated exactly like idle beats.
  assign beat      = iDVAL && (iX_Cont < CNT_W'(IN_WIDTH));
  assign row_tag   = iY_Cont[CNT_W-1:1];
  assign col_addr  = pair_addr(iX_Cont);
  assign paired    = armed && (armed_y == iY_Cont) && ((armed_x + CNT_W'(1)) == iX_Cont);
  assign buf_match = buf_valid && (buf_row == row_tag);

  // When the odd column arrives right after its even partner, the read data
  // has not yet been captured into rd_hold, so take it straight from the RAM.
  assign rd_value  = rd_pending ? rd_data : rd_hold;
  assign pair_sum  = half_sum + PAIR_W'(iDATA);
  assign quad_sum  = QUAD_W'(rd_value) + QUAD_W'(half_sum) + QUAD_W'(iDATA);

  always_comb begin
    next_state = state;
    latch_half = 1'b0;
    arm        = 1'b0;
    disarm     = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    fire       = 1'b0;
    if (beat) begin
      next_state = iY_Cont[0] ? ROW_COMB : ROW_FOLD;
      if (!iX_Cont[0]) begin
        latch_half = 1'b1;
        arm        = 1'b1;
        rd_en      = (next_state == ROW_COMB);
      end else begin
        disarm = 1'b1;
        if (paired) begin
          case (next_state)
            ROW_FOLD: wr_en = 1'b1;
            ROW_COMB: fire  = buf_match;
            default:  fire  = 1'b0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= ROW_FOLD;
      half_sum   <= '0;
      armed      <= 1'b0;
      armed_x    <= '0;
      armed_y    <= '0;
      buf_valid  <= 1'b0;
      buf_row    <= '0;
      rd_pending <= 1'b0;
      rd_hold    <= '0;
    end else begin
      state      <= next_state;
      rd_pending <= rd_en;
      if (rd_pending) begin
        rd_hold <= rd_data;
      end
      if (latch_half) begin
        half_sum <= PAIR_W'(iDATA);
      end
      if (arm) begin
        armed   <= 1'b1;
        armed_x <= iX_Cont;
        armed_y <= iY_Cont;
      end else if (disarm) begin
        armed <= 1'b0;
      end
      if (wr_en) begin
        buf_valid <= 1'b1;
        buf_row   <= row_tag;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oGRAY <= '0;
      oDVAL <= 1'b0;
      oX    <= '0;
      oY    <= '0;
    end else begin
      oDVAL <= fire;
      if (fire) begin
        oGRAY <= DATA_W'(quad_sum >> 2);
        oX    <= iX_Cont[POS_W:1];
        oY    <= iY_Cont[POS_W:1];
      end
    end
  end

  line_buf_sdp #(
    .DEPTH (OUT_WIDTH),
    .WIDTH (PAIR_W),
    .AW    (ADDR_W)
  ) u_line_buf (
    .clk     (iCLK),
    .wr_en   (wr_en),
    .wr_addr (col_addr),
    .wr_data (pair_sum),
    .rd_en   (rd_en),
    .rd_addr (col_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_bayer_quad_gray.sv
// Directed/randomized bench for bayer_quad_gray against a quad-mean model
// that tracks the last folded row as plain pair sums.
module tb_bayer_quad_gray;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [11:0] iDATA = '0;
  logic        iDVAL = 1'b0;
  logic [15:0] iX_Cont = '0;
  logic [15:0] iY_Cont = '0;
  logic [11:0] oGRAY;
  logic        oDVAL;
  logic [9:0]  oX;
  logic [9:0]  oY;

  int total = 0;
  int bad = 0;
  int pulse_count = 0;

  int fold_vals [640];
  int fold_tag = 0;
  bit fold_ok = 1'b0;
  bit pend_ok = 1'b0;
  int pend_x = 0;
  int pend_y = 0;
  int pend_d = 0;

  bit exp_rst;
  bit exp_dval;
  int exp_gray;
  int exp_x;
  int exp_y;

  bayer_quad_gray dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iDATA   (iDATA),
    .iDVAL   (iDVAL),
    .iX_Cont (iX_Cont),
    .iY_Cont (iY_Cont),
    .oGRAY   (oGRAY),
    .oDVAL   (oDVAL),
    .oX      (oX),
    .oY      (oY)
  );

  always #5 iCLK = ~iCLK;

  // Reference: even rows store R+G pair sums per column pair; an odd row pair
  // adds its own pair and the stored one, divided by four, one cycle later.
  task automatic model_step(input bit rst, input bit dval, input int x, input int y, input int d);
    exp_rst  = rst;
    exp_dval = 1'b0;
    if (rst) begin
      fold_ok = 1'b0;
      pend_ok = 1'b0;
    end else if (dval && x < 1280) begin
      if (x % 2 == 0) begin
        pend_ok = 1'b1;
        pend_x  = x;
        pend_y  = y;
        pend_d  = d;
      end else begin
        if (pend_ok && pend_x + 1 == x && pend_y == y) begin
          if (y % 2 == 0) begin
            fold_vals[x / 2] = pend_d + d;
            fold_tag = y / 2;
            fold_ok  = 1'b1;
          end else if (fold_ok && fold_tag == y / 2) begin
            exp_dval = 1'b1;
            exp_gray = (fold_vals[x / 2] + pend_d + d) / 4;
            exp_x    = x / 2;
            exp_y    = (y / 2) % 1024;
          end
        end
        pend_ok = 1'b0;
      end
    end
  endtask

  task automatic checkOutput();
    if (exp_rst) begin
      total++;
      assert (oDVAL === 1'b0) else begin bad++; $error("[TB] FAIL rst_dval obs=%0b exp=0", oDVAL); end
      total++;
      assert (oGRAY === 12'd0) else begin bad++; $error("[TB] FAIL rst_gray obs=%0d exp=0", oGRAY); end
      total++;
      assert (oX === 10'd0) else begin bad++; $error("[TB] FAIL rst_x obs=%0d exp=0", oX); end
      total++;
      assert (oY === 10'd0) else begin bad++; $error("[TB] FAIL rst_y obs=%0d exp=0", oY); end
    end else begin
      total++;
      assert (oDVAL === exp_dval) else begin
        bad++;
        $error("[TB] FAIL dval obs=%0b exp=%0b (x=%0d y=%0d)", oDVAL, exp_dval, iX_Cont, iY_Cont);
      end
      if (exp_dval) begin
        total++;
        assert (oGRAY === 12'(exp_gray)) else begin bad++; $error("[TB] FAIL gray obs=%0d exp=%0d", oGRAY, exp_gray); end
        total++;
        assert (oX === 10'(exp_x)) else begin bad++; $error("[TB] FAIL ox obs=%0d exp=%0d", oX, exp_x); end
        total++;
        assert (oY === 10'(exp_y)) else begin bad++; $error("[TB] FAIL oy obs=%0d exp=%0d", oY, exp_y); end
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit dval, input int x, input int y, input int d);
    @(negedge iCLK);
    iRST    = rst;
    iDVAL   = dval;
    iX_Cont = 16'(x);
    iY_Cont = 16'(y);
    iDATA   = 12'(d);
    @(posedge iCLK);
    #1;
    model_step(rst, dval, x, y, d);
    checkOutput();
    if (oDVAL === 1'b1) pulse_count++;
  endtask

  // Drives columns x0..x1 of row y; idle beats of gap_lo..gap_hi follow each even column.
  task automatic run_row(input int y, input int x0, input int x1, input bit rnd,
                         input int gap_lo, input int gap_hi);
    int d;
    int g;
    for (int x = x0; x <= x1; x++) begin
      d = rnd ? int'($urandom_range(0, 4095)) : 'h800;
      applyStimulus(1'b0, 1'b1, x, y, d);
      if (x % 2 == 0 && gap_hi > 0) begin
        g = int'($urandom_range(gap_lo, gap_hi));
        for (int k = 0; k < g; k++) begin
          applyStimulus(1'b0, 1'b0, x, y, int'($urandom_range(0, 4095)));
        end
      end
    end
  endtask

  task automatic expect_pulses(input string tag, input int want);
    total++;
    assert (pulse_count == want) else begin
      bad++;
      $error("[TB] FAIL %s pulses obs=%0d exp=%0d", tag, pulse_count, want);
    end
    pulse_count = 0;
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);

    // Constant field
    pulse_count = 0;
    run_row(0, 0, 1279, 1'b0, 0, 0);
    expect_pulses("const_fold", 0);
    run_row(1, 0, 1279, 1'b0, 0, 0);
    expect_pulses("const_comb", 640);

    // Quad maximum and truncation
    applyStimulus(1'b0, 1'b1, 0, 0, 4095);
    applyStimulus(1'b0, 1'b1, 1, 0, 4095);
    applyStimulus(1'b0, 1'b1, 2, 0, 1);
    applyStimulus(1'b0, 1'b1, 3, 0, 2);
    applyStimulus(1'b0, 1'b1, 0, 1, 4095);
    applyStimulus(1'b0, 1'b1, 1, 1, 4095);
    total++;
    assert (oGRAY === 12'd4095) else begin bad++; $error("[TB] FAIL quad_max obs=%0d exp=4095", oGRAY); end
    applyStimulus(1'b0, 1'b1, 2, 1, 3);
    applyStimulus(1'b0, 1'b1, 3, 1, 5);
    total++;
    assert (oGRAY === 12'd2) else begin bad++; $error("[TB] FAIL quad_trunc obs=%0d exp=2", oGRAY); end
    pulse_count = 0;

    // Odd row first after a fresh start
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    pulse_count = 0;
    run_row(1, 0, 1279, 1'b1, 0, 0);
    expect_pulses("odd_first", 0);
    run_row(2, 0, 1279, 1'b1, 0, 0);
    run_row(3, 0, 1279, 1'b1, 0, 0);
    expect_pulses("after_odd_first", 640);

    // Idle gaps between even and odd columns
    run_row(4, 0, 1279, 1'b0, 0, 0);
    run_row(5, 0, 1279, 1'b0, 3, 3);
    expect_pulses("fixed_gaps", 640);
    run_row(8, 0, 1279, 1'b1, 0, 2);
    run_row(9, 0, 1279, 1'b1, 0, 3);
    expect_pulses("random_gaps", 640);

    // Reset in the middle of an odd row
    run_row(2, 0, 1279, 1'b1, 0, 0);
    run_row(3, 0, 399, 1'b1, 0, 0);
    applyStimulus(1'b1, 1'b1, 400, 3, int'($urandom_range(0, 4095)));
    pulse_count = 0;
    run_row(3, 401, 1279, 1'b1, 0, 0);
    expect_pulses("after_reset_row", 0);
    run_row(4, 0, 1279, 1'b1, 0, 0);
    run_row(5, 0, 1279, 1'b1, 0, 0);
    expect_pulses("resume_after_reset", 640);

    // Columns at and beyond the active width
    run_row(6, 0, 1279, 1'b1, 0, 0);
    run_row(6, 1280, 1283, 1'b1, 0, 0);
    expect_pulses("limit_fold", 0);
    run_row(7, 0, 1279, 1'b1, 0, 0);
    expect_pulses("limit_comb", 640);
    run_row(7, 1280, 1283, 1'b1, 0, 0);
    expect_pulses("limit_odd", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
